// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and load/store.
// MEM has fixed priority; each access runs IDLE -> BUSY_x -> DONE with a bounded wait for ram_ack.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_BUSY_IF  = 2'd1;
    localparam logic [1:0] ST_BUSY_MEM = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;
    localparam logic [3:0] TIMEOUT_M1  = 4'(TIMEOUT - 1);

    logic [1:0]        state_r, state_nx_s;
    logic [3:0]        cnt_r, cnt_nx_s;
    logic              ram_req_r, ram_req_nx_s;
    logic              ram_we_r, ram_we_nx_s;
    logic [ADDR_W-1:0] ram_addr_r, ram_addr_nx_s;
    logic [DATA_W-1:0] ram_wdata_r, ram_wdata_nx_s;
    logic [DATA_W-1:0] if_rdata_r, if_rdata_nx_s;
    logic [DATA_W-1:0] mem_rdata_r, mem_rdata_nx_s;
    logic              if_ready_r, if_ready_nx_s;
    logic              mem_ready_r, mem_ready_nx_s;
    logic              err_r, err_nx_s;
    logic              mem_any_s;
    logic              timeout_s;

    assign mem_any_s = mem_rd | mem_wr;
    // The counter value TIMEOUT-1 marks the last permitted BUSY cycle.
    assign timeout_s = (cnt_r == TIMEOUT_M1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; requests are only considered in IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_any_s) begin
                    state_nx_s = ST_BUSY_MEM;
                end else if (if_req) begin
                    state_nx_s = ST_BUSY_IF;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY_IF, ST_BUSY_MEM: begin
                if (ram_ack || timeout_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and wait counter.
    always_comb begin
        cnt_nx_s       = cnt_r;
        ram_req_nx_s   = ram_req_r;
        ram_we_nx_s    = ram_we_r;
        ram_addr_nx_s  = ram_addr_r;
        ram_wdata_nx_s = ram_wdata_r;
        if_rdata_nx_s  = if_rdata_r;
        mem_rdata_nx_s = mem_rdata_r;
        if_ready_nx_s  = 1'b0;
        mem_ready_nx_s = 1'b0;
        err_nx_s       = err_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_any_s) begin
                    ram_req_nx_s   = 1'b1;
                    ram_we_nx_s    = mem_wr;
                    ram_addr_nx_s  = mem_addr;
                    ram_wdata_nx_s = mem_wdata;
                end else if (if_req) begin
                    ram_req_nx_s  = 1'b1;
                    ram_we_nx_s   = 1'b0;
                    ram_addr_nx_s = if_addr;
                end else begin
                    ram_req_nx_s = 1'b0;
                end
            end
            ST_BUSY_IF: begin
                cnt_nx_s = cnt_r + 4'd1;
                if (ram_ack) begin
                    ram_req_nx_s  = 1'b0;
                    if_rdata_nx_s = ram_rdata;
                    if_ready_nx_s = 1'b1;
                end else if (timeout_s) begin
                    ram_req_nx_s  = 1'b0;
                    err_nx_s      = 1'b1;
                    if_rdata_nx_s = {DATA_W{1'b0}};
                    if_ready_nx_s = 1'b1;
                end else begin
                    ram_req_nx_s = 1'b1;
                end
            end
            ST_BUSY_MEM: begin
                cnt_nx_s = cnt_r + 4'd1;
                if (ram_ack) begin
                    ram_req_nx_s   = 1'b0;
                    mem_ready_nx_s = 1'b1;
                    if (!ram_we_r) begin
                        mem_rdata_nx_s = ram_rdata;
                    end else begin
                        mem_rdata_nx_s = mem_rdata_r;
                    end
                end else if (timeout_s) begin
                    ram_req_nx_s   = 1'b0;
                    err_nx_s       = 1'b1;
                    mem_rdata_nx_s = {DATA_W{1'b0}};
                    mem_ready_nx_s = 1'b1;
                end else begin
                    ram_req_nx_s = 1'b1;
                end
            end
            ST_DONE: begin
                cnt_nx_s     = 4'd0;
                ram_req_nx_s = 1'b0;
            end
            default: begin
                cnt_nx_s     = 4'd0;
                ram_req_nx_s = 1'b0;
            end
        endcase
    end

    // Output and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= 4'd0;
            ram_req_r   <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_wdata_r <= {DATA_W{1'b0}};
            if_rdata_r  <= {DATA_W{1'b0}};
            mem_rdata_r <= {DATA_W{1'b0}};
            if_ready_r  <= 1'b0;
            mem_ready_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            cnt_r       <= cnt_nx_s;
            ram_req_r   <= ram_req_nx_s;
            ram_we_r    <= ram_we_nx_s;
            ram_addr_r  <= ram_addr_nx_s;
            ram_wdata_r <= ram_wdata_nx_s;
            if_rdata_r  <= if_rdata_nx_s;
            mem_rdata_r <= mem_rdata_nx_s;
            if_ready_r  <= if_ready_nx_s;
            mem_ready_r <= mem_ready_nx_s;
            err_r       <= err_nx_s;
        end
    end

    assign ram_req   = ram_req_r;
    assign ram_we    = ram_we_r;
    assign ram_addr  = ram_addr_r;
    assign ram_wdata = ram_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign mem_rdata = mem_rdata_r;
    assign if_ready  = if_ready_r;
    assign mem_ready = mem_ready_r;
    assign err       = err_r;
    assign stall_if  = if_req & ~if_ready_r;
    assign stall_mem = mem_any_s & ~mem_ready_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario, inline comparisons.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ready;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        ram_req;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; ram_ack = 1'b0;
        if_addr = 16'h0000; mem_addr = 16'h0000; mem_wdata = 16'h0000; ram_rdata = 16'h0000;
        step(); step();
        total++; if ({ram_req, ram_we, if_ready, mem_ready, err} !== 5'b00000) begin bad++; $display("FAIL reset_ctrl got=%b exp=00000", {ram_req, ram_we, if_ready, mem_ready, err}); end
        total++; if ({ram_addr, ram_wdata, if_rdata, mem_rdata} !== 64'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {ram_addr, ram_wdata, if_rdata, mem_rdata}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 16'h0040;
        #1;
        total++; if (stall_if !== 1'b1 || ram_req !== 1'b0) begin bad++; $display("FAIL fetch_c0 got stall=%b req=%b exp 1 0", stall_if, ram_req); end
        step();
        total++; if (ram_req !== 1'b1 || ram_addr !== 16'h0040 || ram_we !== 1'b0 || stall_if !== 1'b1) begin bad++; $display("FAIL fetch_c1 got req=%b addr=%h we=%b stall=%b", ram_req, ram_addr, ram_we, stall_if); end
        ram_ack = 1'b1; ram_rdata = 16'h1234;
        step();
        total++; if (if_ready !== 1'b1 || if_rdata !== 16'h1234 || ram_req !== 1'b0 || stall_if !== 1'b0) begin bad++; $display("FAIL fetch_c2 got rdy=%b data=%h req=%b stall=%b exp 1 1234 0 0", if_ready, if_rdata, ram_req, stall_if); end
        ram_ack = 1'b0; if_req = 1'b0;
        step();
        total++; if (if_ready !== 1'b0 || ram_req !== 1'b0) begin bad++; $display("FAIL fetch_c3 got rdy=%b req=%b exp 0 0", if_ready, ram_req); end
    endtask

    task automatic test_priority();
        if_req = 1'b1; if_addr = 16'h0200; mem_rd = 1'b1; mem_addr = 16'h0100;
        step();
        total++; if (ram_req !== 1'b1 || ram_addr !== 16'h0100 || ram_we !== 1'b0) begin bad++; $display("FAIL prio_grant got req=%b addr=%h we=%b exp 1 0100 0", ram_req, ram_addr, ram_we); end
        step(); step();
        total++; if (ram_req !== 1'b1 || stall_if !== 1'b1 || stall_mem !== 1'b1) begin bad++; $display("FAIL prio_wait got req=%b sif=%b smem=%b exp 1 1 1", ram_req, stall_if, stall_mem); end
        ram_ack = 1'b1; ram_rdata = 16'hA5A5;
        step();
        total++; if (mem_ready !== 1'b1 || mem_rdata !== 16'hA5A5 || if_ready !== 1'b0 || stall_if !== 1'b1) begin bad++; $display("FAIL prio_done got mrdy=%b data=%h irdy=%b sif=%b", mem_ready, mem_rdata, if_ready, stall_if); end
        ram_ack = 1'b0; mem_rd = 1'b0;
        step();
        total++; if (ram_req !== 1'b0 || stall_if !== 1'b1 || mem_ready !== 1'b0) begin bad++; $display("FAIL prio_idle got req=%b sif=%b mrdy=%b exp 0 1 0", ram_req, stall_if, mem_ready); end
        step();
        total++; if (ram_req !== 1'b1 || ram_addr !== 16'h0200 || stall_if !== 1'b1) begin bad++; $display("FAIL prio_if_grant got req=%b addr=%h sif=%b exp 1 0200 1", ram_req, ram_addr, stall_if); end
        ram_ack = 1'b1; ram_rdata = 16'h5555;
        step();
        total++; if (if_ready !== 1'b1 || if_rdata !== 16'h5555) begin bad++; $display("FAIL prio_if_done got rdy=%b data=%h exp 1 5555", if_ready, if_rdata); end
        ram_ack = 1'b0; if_req = 1'b0;
        step();
    endtask

    task automatic test_store();
        mem_wr = 1'b1; mem_addr = 16'h0008; mem_wdata = 16'hBEEF;
        step();
        total++; if (ram_req !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== 16'hBEEF || ram_addr !== 16'h0008) begin bad++; $display("FAIL store_req got req=%b we=%b wd=%h addr=%h", ram_req, ram_we, ram_wdata, ram_addr); end
        mem_wr = 1'b0; mem_wdata = 16'h0000;
        ram_ack = 1'b1; ram_rdata = 16'h1111;
        step();
        total++; if (mem_ready !== 1'b1 || mem_rdata !== 16'hA5A5 || err !== 1'b0) begin bad++; $display("FAIL store_done got rdy=%b rdata=%h err=%b exp 1 a5a5 0", mem_ready, mem_rdata, err); end
        ram_ack = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int n;
        mem_rd = 1'b1; mem_addr = 16'h0030;
        step();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (ram_req === 1'b1) begin
                n++;
                step();
            end
        end
        total++; if (n !== 15) begin bad++; $display("FAIL timeout_len got=%0d exp=15", n); end
        total++; if (mem_ready !== 1'b1 || mem_rdata !== 16'h0000 || err !== 1'b1) begin bad++; $display("FAIL timeout_done got rdy=%b rdata=%h err=%b exp 1 0000 1", mem_ready, mem_rdata, err); end
        mem_rd = 1'b0;
        step(); step();
        total++; if (err !== 1'b1 || mem_ready !== 1'b0) begin bad++; $display("FAIL timeout_sticky got err=%b rdy=%b exp 1 0", err, mem_ready); end
    endtask

    task automatic test_reset_midflight();
        if_req = 1'b1; if_addr = 16'h0044;
        step(); step();
        total++; if (ram_req !== 1'b1) begin bad++; $display("FAIL rstmid_busy got req=%b exp 1", ram_req); end
        rst = 1'b1; if_req = 1'b0;
        step();
        total++; if (ram_req !== 1'b0 || err !== 1'b0 || if_ready !== 1'b0) begin bad++; $display("FAIL rstmid_edge got req=%b err=%b rdy=%b exp 0 0 0", ram_req, err, if_ready); end
        rst = 1'b0; ram_ack = 1'b1; ram_rdata = 16'hDEAD;
        step();
        total++; if (if_ready !== 1'b0 || if_rdata !== 16'h0000 || ram_req !== 1'b0) begin bad++; $display("FAIL rstmid_late_ack got rdy=%b data=%h req=%b exp 0 0000 0", if_ready, if_rdata, ram_req); end
        step();
        total++; if (if_ready !== 1'b0 || mem_ready !== 1'b0) begin bad++; $display("FAIL rstmid_quiet got irdy=%b mrdy=%b exp 0 0", if_ready, mem_ready); end
        ram_ack = 1'b0;
    endtask

    task automatic test_stray_ack();
        ram_ack = 1'b1; ram_rdata = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({if_ready, mem_ready, ram_req} !== 3'b000) begin bad++; $display("FAIL stray_ack_%0d got=%b exp=000", i, {if_ready, mem_ready, ram_req}); end
        end
        ram_ack = 1'b0;
        if_req = 1'b1; if_addr = 16'h0123;
        step();
        total++; if (ram_req !== 1'b1 || ram_addr !== 16'h0123) begin bad++; $display("FAIL stray_idle got req=%b addr=%h exp 1 0123", ram_req, ram_addr); end
        ram_ack = 1'b1; ram_rdata = 16'h4242;
        step();
        total++; if (if_ready !== 1'b1 || if_rdata !== 16'h4242) begin bad++; $display("FAIL stray_after got rdy=%b data=%h exp 1 4242", if_ready, if_rdata); end
        ram_ack = 1'b0; if_req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_timeout();
        test_reset_midflight();
        test_stray_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
